// File: rtl/clk_cfg_seq.sv
// Safe-order sequencer for the clock controller: parks on 8 MHz, brings up the PLL,
// switches selects and divider, then releases. Optional PLL tick check: PLL_LOCK_CHK_EN.
module clk_cfg_seq #(
   parameter int MUX_SETTLE_CYC = 8,
   parameter int PLL_LOCK_CYC   = 256,
   parameter int CNT_W          = 16
`ifdef PLL_LOCK_CHK_EN
   ,
   parameter int MIN_TICKS      = 4
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       cfg_pll,
   input  logic       cfg_8mhz,
   input  logic [1:0] cfg_rosc,
   input  logic [1:0] cfg_trim,
   input  logic [1:0] cfg_div,
`ifdef PLL_LOCK_CHK_EN
   input  logic       pll_tick,
`endif
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       pll_en,
   output logic [1:0] pll_trim,
   output logic       sel_pll,
   output logic       sel_8mhz,
   output logic [1:0] sel_rosc,
   output logic [1:0] clk_div
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SAFE     = 3'd1,
      PLL_WAIT = 3'd2,
      SEL      = 3'd3,
      DIV      = 3'd4,
      REL      = 3'd5,
      FIN      = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] S_LD     = CNT_W'(MUX_SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] L_LD     = CNT_W'(PLL_LOCK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sh_pll_q, sh_pll_d;
   logic             sh_8mhz_q, sh_8mhz_d;
   logic [1:0]       sh_rosc_q, sh_rosc_d;
   logic [1:0]       sh_trim_q, sh_trim_d;
   logic [1:0]       sh_div_q, sh_div_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             pll_en_q, pll_en_d;
   logic [1:0]       pll_trim_q, pll_trim_d;
   logic             sel_pll_q, sel_pll_d;
   logic             sel_8mhz_q, sel_8mhz_d;
   logic [1:0]       sel_rosc_q, sel_rosc_d;
   logic [1:0]       clk_div_q, clk_div_d;
   logic             cnt_zero_s;
   logic             pll_needed_s;

`ifdef PLL_LOCK_CHK_EN
   localparam int TC_W = $clog2(MIN_TICKS + 1);
   localparam logic [TC_W-1:0] TC_MAX = TC_W'(MIN_TICKS);
   logic            tick_s1_q, tick_s2_q, tick_s3_q;
   logic [TC_W-1:0] tick_cnt_q, tick_cnt_d, tick_cnt_s;
   logic            tick_rise_s;

   assign tick_rise_s = tick_s2_q & ~tick_s3_q;
   assign tick_cnt_s  = (tick_rise_s && (tick_cnt_q < TC_MAX)) ? (tick_cnt_q + TC_W'(1)) : tick_cnt_q;
`endif

   assign cnt_zero_s   = (cnt_q == CNT_ZERO);
   // A PLL already running at the requested trim needs no fresh lock wait.
   assign pll_needed_s = sh_pll_q & ~(pll_en_q & (pll_trim_q == sh_trim_q));

   // Next state, wait counter, shadow capture and next output values
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_zero_s ? CNT_ZERO : (cnt_q - CNT_ONE);
      sh_pll_d   = sh_pll_q;
      sh_8mhz_d  = sh_8mhz_q;
      sh_rosc_d  = sh_rosc_q;
      sh_trim_d  = sh_trim_q;
      sh_div_d   = sh_div_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      pll_en_d   = pll_en_q;
      pll_trim_d = pll_trim_q;
      sel_pll_d  = sel_pll_q;
      sel_8mhz_d = sel_8mhz_q;
      sel_rosc_d = sel_rosc_q;
      clk_div_d  = clk_div_q;
`ifdef PLL_LOCK_CHK_EN
      tick_cnt_d = tick_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               sh_pll_d  = cfg_pll;
               sh_8mhz_d = cfg_8mhz;
               sh_rosc_d = cfg_rosc;
               sh_trim_d = cfg_trim;
               sh_div_d  = cfg_div;
               busy_d    = 1'b1;
               state_d   = SAFE;
               cnt_d     = S_LD;
            end else begin
               busy_d    = 1'b0;
            end
         end
         SAFE: begin
            sel_8mhz_d = 1'b1;
            if (cnt_zero_s && pll_needed_s) begin
               state_d = PLL_WAIT;
               cnt_d   = L_LD;
`ifdef PLL_LOCK_CHK_EN
               tick_cnt_d = {TC_W{1'b0}};
`endif
            end else if (cnt_zero_s) begin
               state_d = SEL;
               cnt_d   = S_LD;
            end else begin
               state_d = SAFE;
            end
         end
         PLL_WAIT: begin
            pll_en_d   = 1'b1;
            pll_trim_d = sh_trim_q;
`ifdef PLL_LOCK_CHK_EN
            tick_cnt_d = tick_cnt_s;
            // Too few PLL ticks: drop the PLL and finish the sequence without it.
            if (cnt_zero_s && (tick_cnt_s < TC_MAX)) begin
               pll_en_d = 1'b0;
               sh_pll_d = 1'b0;
               err_d    = 1'b1;
            end else begin
               err_d    = err_q;
            end
`endif
            if (cnt_zero_s) begin
               state_d = SEL;
               cnt_d   = S_LD;
            end else begin
               state_d = PLL_WAIT;
            end
         end
         SEL: begin
            sel_pll_d  = sh_pll_q;
            sel_rosc_d = sh_rosc_q;
            if (cnt_zero_s) begin
               state_d = DIV;
               cnt_d   = S_LD;
            end else begin
               state_d = SEL;
            end
         end
         DIV: begin
            clk_div_d = sh_div_q;
            if (cnt_zero_s) begin
               state_d = REL;
               cnt_d   = S_LD;
            end else begin
               state_d = DIV;
            end
         end
         REL: begin
            sel_8mhz_d = sh_8mhz_q;
            if (cnt_zero_s) begin
               state_d = FIN;
            end else begin
               state_d = REL;
            end
         end
         FIN: begin
            if (!sh_pll_q) begin
               pll_en_d = 1'b0;
            end else begin
               pll_en_d = pll_en_q;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, shadow and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= CNT_ZERO;
         sh_pll_q   <= 1'b0;
         sh_8mhz_q  <= 1'b1;
         sh_rosc_q  <= 2'd0;
         sh_trim_q  <= 2'd0;
         sh_div_q   <= 2'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         pll_en_q   <= 1'b0;
         pll_trim_q <= 2'd0;
         sel_pll_q  <= 1'b0;
         sel_8mhz_q <= 1'b1;
         sel_rosc_q <= 2'd0;
         clk_div_q  <= 2'd0;
`ifdef PLL_LOCK_CHK_EN
         tick_s1_q  <= 1'b0;
         tick_s2_q  <= 1'b0;
         tick_s3_q  <= 1'b0;
         tick_cnt_q <= {TC_W{1'b0}};
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_pll_q   <= sh_pll_d;
         sh_8mhz_q  <= sh_8mhz_d;
         sh_rosc_q  <= sh_rosc_d;
         sh_trim_q  <= sh_trim_d;
         sh_div_q   <= sh_div_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         pll_en_q   <= pll_en_d;
         pll_trim_q <= pll_trim_d;
         sel_pll_q  <= sel_pll_d;
         sel_8mhz_q <= sel_8mhz_d;
         sel_rosc_q <= sel_rosc_d;
         clk_div_q  <= clk_div_d;
`ifdef PLL_LOCK_CHK_EN
         tick_s1_q  <= pll_tick;
         tick_s2_q  <= tick_s1_q;
         tick_s3_q  <= tick_s2_q;
         tick_cnt_q <= tick_cnt_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign pll_en   = pll_en_q;
   assign pll_trim = pll_trim_q;
   assign sel_pll  = sel_pll_q;
   assign sel_8mhz = sel_8mhz_q;
   assign sel_rosc = sel_rosc_q;
   assign clk_div  = clk_div_q;

endmodule
